// File: rtl/cfg_req_width_bridge_if.sv
// Config request/ack bundle seen by the width bridge: one wide upstream
// request/ack pair and one narrow downstream request/ack pair.
// slave  : the bridge itself (takes upstream requests, drives downstream).
// master : the surrounding fabric / register bank model.
interface cfg_req_width_bridge_if #(
    parameter int UP_W   = 64,
    parameter int DN_W   = 32,
    parameter int ADDR_W = 48
);
    // upstream request
    logic                up_req_valid;
    logic                up_req_ready;
    logic [3:0]          up_req_opcode;
    logic [ADDR_W-1:0]   up_req_addr;
    logic [UP_W/8-1:0]   up_req_be;
    logic [UP_W-1:0]     up_req_data;
    logic [7:0]          up_req_sai;
    logic [7:0]          up_req_fid;
    logic [2:0]          up_req_bar;
    // upstream merged ack
    logic                up_ack_read_valid;
    logic                up_ack_read_miss;
    logic                up_ack_write_valid;
    logic                up_ack_write_miss;
    logic                up_ack_sai_successfull;
    logic [UP_W-1:0]     up_ack_data;
    // downstream beat request
    logic                dn_req_valid;
    logic [3:0]          dn_req_opcode;
    logic [ADDR_W-1:0]   dn_req_addr;
    logic [DN_W/8-1:0]   dn_req_be;
    logic [DN_W-1:0]     dn_req_data;
    logic [7:0]          dn_req_sai;
    logic [7:0]          dn_req_fid;
    logic [2:0]          dn_req_bar;
    // downstream beat ack
    logic                dn_ack_read_valid;
    logic                dn_ack_read_miss;
    logic                dn_ack_write_valid;
    logic                dn_ack_write_miss;
    logic                dn_ack_sai_successfull;
    logic [DN_W-1:0]     dn_ack_data;

    modport slave (
        input  up_req_valid, up_req_opcode, up_req_addr, up_req_be, up_req_data,
               up_req_sai, up_req_fid, up_req_bar,
        output up_req_ready,
        output up_ack_read_valid, up_ack_read_miss, up_ack_write_valid,
               up_ack_write_miss, up_ack_sai_successfull, up_ack_data,
        output dn_req_valid, dn_req_opcode, dn_req_addr, dn_req_be, dn_req_data,
               dn_req_sai, dn_req_fid, dn_req_bar,
        input  dn_ack_read_valid, dn_ack_read_miss, dn_ack_write_valid,
               dn_ack_write_miss, dn_ack_sai_successfull, dn_ack_data
    );

    modport master (
        output up_req_valid, up_req_opcode, up_req_addr, up_req_be, up_req_data,
               up_req_sai, up_req_fid, up_req_bar,
        input  up_req_ready,
        input  up_ack_read_valid, up_ack_read_miss, up_ack_write_valid,
               up_ack_write_miss, up_ack_sai_successfull, up_ack_data,
        input  dn_req_valid, dn_req_opcode, dn_req_addr, dn_req_be, dn_req_data,
               dn_req_sai, dn_req_fid, dn_req_bar,
        output dn_ack_read_valid, dn_ack_read_miss, dn_ack_write_valid,
               dn_ack_write_miss, dn_ack_sai_successfull, dn_ack_data
    );
endinterface

// File: rtl/cfg_req_width_bridge.sv
// Splits one UP_W-bit config request into DN_W-bit downstream beats, one beat
// outstanding at a time, skipping beats whose byte enables are all zero, and
// merges the beat acks into a single upstream ack. Illegal opcodes (>7) and
// all-zero-be requests are answered without downstream traffic.
module cfg_req_width_bridge #(
    parameter int UP_W   = 64,
    parameter int DN_W   = 32,
    parameter int ADDR_W = 48,
    parameter int TMO_W  = 8,
    parameter int TMO_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cfg_req_width_bridge_if.slave  bus
);
    localparam int RATIO  = UP_W / DN_W;
    localparam int UPB    = UP_W / 8;
    localparam int DNB    = DN_W / 8;
    localparam int DNB_LG = $clog2(DNB);
    localparam int BW     = (RATIO > 1) ? $clog2(RATIO) : 1;
    // low address bits dropped to align the request to the upstream width
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(UPB - 1);
    // the cycle whose increment makes the counter all-ones ends the wait
    localparam logic [TMO_W-1:0]  TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic [3:0]          op_q;
    logic [ADDR_W-1:0]   base_q;
    logic [UPB-1:0]      be_q;
    logic [UP_W-1:0]     data_q;
    logic [UP_W-1:0]     rdata_q;
    logic [7:0]          sai_q, fid_q;
    logic [2:0]          bar_q;
    logic [BW-1:0]       beat_q;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                miss_q;
    logic                sai_ok_q;

    logic                is_rd;
    logic                ack_any, ack_good, tmo_hit;
    logic [UPB-1:0]      srch_be;
    int                  srch_from;
    logic                nb_found;
    logic [BW-1:0]       nb_idx;

    assign is_rd    = ~op_q[0];
    assign ack_any  = bus.dn_ack_read_valid | bus.dn_ack_read_miss |
                      bus.dn_ack_write_valid | bus.dn_ack_write_miss;
    // only a clean ack of the matching kind counts; anything else is a miss
    assign ack_good = is_rd ?
        (bus.dn_ack_read_valid & ~bus.dn_ack_read_miss & ~bus.dn_ack_write_valid & ~bus.dn_ack_write_miss) :
        (bus.dn_ack_write_valid & ~bus.dn_ack_write_miss & ~bus.dn_ack_read_valid & ~bus.dn_ack_read_miss);
    assign tmo_hit  = (TMO_EN != 0) && (tmo_cnt == TMO_LAST);

    // find the first beat with nonzero byte enables at or after the search start:
    // from beat 0 of the incoming request in IDLE, else after the current beat
    always_comb begin
        srch_be   = be_q;
        srch_from = int'(beat_q) + 1;
        if (state == IDLE) begin
            srch_be   = bus.up_req_be;
            srch_from = 0;
        end
        nb_found = 1'b0;
        nb_idx   = '0;
        for (int k = RATIO - 1; k >= 0; k--) begin
            if (k >= srch_from && srch_be[k*DNB +: DNB] != '0) begin
                nb_found = 1'b1;
                nb_idx   = BW'(k);
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.up_req_valid)
                       state_nxt = (bus.up_req_opcode[3] || !nb_found) ? RESP : ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (ack_any)      state_nxt = (ack_good && nb_found) ? ISSUE : RESP;
                   else if (tmo_hit) state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // request capture, beat tracking, timeout counter and ack merging
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            base_q   <= '0;
            be_q     <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            sai_q    <= '0;
            fid_q    <= '0;
            bar_q    <= '0;
            beat_q   <= '0;
            tmo_cnt  <= '0;
            miss_q   <= 1'b0;
            sai_ok_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.up_req_valid) begin
                    op_q     <= bus.up_req_opcode;
                    base_q   <= bus.up_req_addr & ~OFF_MASK;
                    be_q     <= bus.up_req_be;
                    data_q   <= bus.up_req_data;
                    sai_q    <= bus.up_req_sai;
                    fid_q    <= bus.up_req_fid;
                    bar_q    <= bus.up_req_bar;
                    beat_q   <= nb_idx;
                    rdata_q  <= '0;
                    sai_ok_q <= 1'b1;
                    // an illegal opcode is answered as a miss straight away
                    miss_q   <= bus.up_req_opcode[3];
                end
                ISSUE: tmo_cnt <= '0;
                WAIT: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (ack_any) begin
                        if (ack_good) begin
                            if (is_rd) rdata_q[int'(beat_q)*DN_W +: DN_W] <= bus.dn_ack_data;
                            sai_ok_q <= sai_ok_q & bus.dn_ack_sai_successfull;
                            if (nb_found) beat_q <= nb_idx;
                        end else begin
                            miss_q <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        miss_q   <= 1'b1;
                        sai_ok_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // downstream beat fields are held from ISSUE until that beat's ack
    assign bus.up_req_ready   = (state == IDLE);
    assign bus.dn_req_valid   = (state == ISSUE);
    assign bus.dn_req_opcode  = op_q;
    assign bus.dn_req_addr    = base_q + (ADDR_W'(beat_q) << DNB_LG);
    assign bus.dn_req_be      = be_q[int'(beat_q)*DNB +: DNB];
    assign bus.dn_req_data    = data_q[int'(beat_q)*DN_W +: DN_W];
    assign bus.dn_req_sai     = sai_q;
    assign bus.dn_req_fid     = fid_q;
    assign bus.dn_req_bar     = bar_q;

    // merged ack: exactly one pulse during RESP
    assign bus.up_ack_read_valid      = (state == RESP) &  is_rd & ~miss_q;
    assign bus.up_ack_read_miss       = (state == RESP) &  is_rd &  miss_q;
    assign bus.up_ack_write_valid     = (state == RESP) & ~is_rd & ~miss_q;
    assign bus.up_ack_write_miss      = (state == RESP) & ~is_rd &  miss_q;
    assign bus.up_ack_sai_successfull = (state == RESP) & sai_ok_q;
    assign bus.up_ack_data            = (state == RESP) ? rdata_q : '0;
endmodule

// File: tb/tb_cfg_req_width_bridge.sv
// Scoreboard bench for cfg_req_width_bridge at UP_W=64, DN_W=32, TMO_W=4.
module tb_cfg_req_width_bridge;
    localparam int UP_W = 64, DN_W = 32, ADDR_W = 48, TMO_W = 4;
    localparam logic [3:0] RV = 4'b1000, RM = 4'b0100, WV = 4'b0010, WM = 4'b0001;

    typedef struct {
        logic [3:0] op; logic [ADDR_W-1:0] addr; logic [3:0] be; logic [31:0] data;
        logic [7:0] sai; logic [7:0] fid; logic [2:0] bar;
    } dn_exp_t;
    typedef struct { logic [3:0] flags; logic [63:0] data; logic sai; bit chk_ds; } up_exp_t;
    typedef struct { int dly; logic [3:0] flags; logic [31:0] data; logic sai; } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cfg_req_width_bridge_if #(.UP_W(UP_W), .DN_W(DN_W), .ADDR_W(ADDR_W)) bus();
    cfg_req_width_bridge #(.UP_W(UP_W), .DN_W(DN_W), .ADDR_W(ADDR_W), .TMO_W(TMO_W), .TMO_EN(1))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    dn_exp_t dn_q[$];
    up_exp_t up_q[$];
    rsp_t    rsp_q[$];
    int n_chk = 0, n_err = 0;
    int cyc = 0, send_cyc = 0, dn_cyc = 0, ack_cyc = 0, dn_cnt = 0, ack_cnt = 0;
    logic [7:0] g_sai = 8'h00, g_fid = 8'h00;
    logic [2:0] g_bar = 3'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_dn(input logic [3:0] op, input logic [ADDR_W-1:0] addr,
                           input logic [3:0] be, input logic [31:0] data);
        dn_q.push_back('{op, addr, be, data, g_sai, g_fid, g_bar});
    endtask

    task automatic push_rsp(input int dly, input logic [3:0] flags, input logic [31:0] data, input logic sai);
        rsp_q.push_back('{dly, flags, data, sai});
    endtask

    task automatic push_up(input logic [3:0] flags, input logic [63:0] data, input logic sai, input bit chk_ds);
        up_q.push_back('{flags, data, sai, chk_ds});
    endtask

    // caller sits just after a rising edge
    task automatic send(input logic [3:0] op, input logic [ADDR_W-1:0] addr,
                        input logic [7:0] be, input logic [63:0] data);
        int n = 0;
        while (!bus.up_req_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("send_ready_timeout", 64'(n >= 50), 0);
        bus.up_req_opcode = op;    bus.up_req_addr = addr; bus.up_req_be = be;
        bus.up_req_data   = data;  bus.up_req_sai  = g_sai; bus.up_req_fid = g_fid;
        bus.up_req_bar    = g_bar; bus.up_req_valid = 1'b1;
        send_cyc = cyc;
        @(posedge clk); #1;
        bus.up_req_valid = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while ((up_q.size() != 0 || dn_q.size() != 0 || !bus.up_req_ready) && n < max) begin
            @(posedge clk); #1; n++;
        end
        chk("wait_done_timeout", 64'(n >= max), 0);
    endtask

    // monitor: compare downstream beats and upstream acks against the scoreboard
    initial begin
        dn_exp_t e;
        up_exp_t u;
        logic [3:0] f;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.dn_req_valid) begin
                    dn_cnt++; dn_cyc = cyc;
                    if (dn_q.size() == 0) chk("dn_unexpected", {32'd0, bus.dn_req_addr[31:0]}, 0);
                    else begin
                        e = dn_q.pop_front();
                        chk("dn_op",   64'(bus.dn_req_opcode), 64'(e.op));
                        chk("dn_addr", 64'(bus.dn_req_addr),   64'(e.addr));
                        chk("dn_be",   64'(bus.dn_req_be),     64'(e.be));
                        chk("dn_data", 64'(bus.dn_req_data),   64'(e.data));
                        chk("dn_attr", 64'({bus.dn_req_sai, bus.dn_req_fid, bus.dn_req_bar}),
                                       64'({e.sai, e.fid, e.bar}));
                    end
                end
                f = {bus.up_ack_read_valid, bus.up_ack_read_miss, bus.up_ack_write_valid, bus.up_ack_write_miss};
                if (f != 4'b0) begin
                    ack_cnt++; ack_cyc = cyc;
                    if (up_q.size() == 0) chk("up_unexpected", 64'(f), 0);
                    else begin
                        u = up_q.pop_front();
                        chk("up_flags", 64'(f), 64'(u.flags));
                        if (u.chk_ds) begin
                            chk("up_data", bus.up_ack_data, u.data);
                            chk("up_sai", 64'(bus.up_ack_sai_successfull), 64'(u.sai));
                        end
                    end
                end
            end
        end
    end

    // downstream responder: one planned response per issued beat
    initial begin
        rsp_t r;
        bus.dn_ack_read_valid = 0; bus.dn_ack_read_miss = 0; bus.dn_ack_write_valid = 0;
        bus.dn_ack_write_miss = 0; bus.dn_ack_sai_successfull = 0; bus.dn_ack_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.dn_req_valid) begin
                r = '{0, 4'b0, 32'b0, 1'b0};
                if (rsp_q.size() != 0) r = rsp_q.pop_front();
                if (r.flags != 4'b0) begin
                    repeat (r.dly) @(posedge clk);
                    #1;
                    {bus.dn_ack_read_valid, bus.dn_ack_read_miss, bus.dn_ack_write_valid,
                     bus.dn_ack_write_miss} = r.flags;
                    bus.dn_ack_data = r.data; bus.dn_ack_sai_successfull = r.sai;
                    @(posedge clk); #1;
                    {bus.dn_ack_read_valid, bus.dn_ack_read_miss, bus.dn_ack_write_valid,
                     bus.dn_ack_write_miss} = 4'b0;
                    bus.dn_ack_data = '0; bus.dn_ack_sai_successfull = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"}, 64'(bus.up_req_ready), 1);
        chk({tag, "_pulses"}, 64'({bus.up_ack_read_valid, bus.up_ack_read_miss, bus.up_ack_write_valid,
                                   bus.up_ack_write_miss, bus.up_ack_sai_successfull, bus.dn_req_valid}), 0);
        chk({tag, "_ack_data"}, bus.up_ack_data, 0);
        chk({tag, "_dn_fields"}, 64'({bus.dn_req_addr, bus.dn_req_be, bus.dn_req_opcode}), 0);
        chk({tag, "_dn_data"}, 64'({bus.dn_req_data, bus.dn_req_sai, bus.dn_req_fid, bus.dn_req_bar}), 0);
    endtask

    initial begin
        int d0, a0, n;
        bus.up_req_valid = 0; bus.up_req_opcode = 0; bus.up_req_addr = 0; bus.up_req_be = 0;
        bus.up_req_data = 0; bus.up_req_sai = 0; bus.up_req_fid = 0; bus.up_req_bar = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // two-beat write
        g_sai = 8'h5A; g_fid = 8'h03; g_bar = 3'd2;
        push_dn(4'h1, 48'h1000, 4'hF, 32'h55667788);
        push_dn(4'h1, 48'h1004, 4'hF, 32'h11223344);
        push_rsp(1, WV, 0, 1'b1); push_rsp(1, WV, 0, 1'b1);
        push_up(WV, 64'h0, 1'b1, 1);
        send(4'h1, 48'h1000, 8'hFF, 64'h11223344_55667788);
        wait_done(100);

        // upper-half read only: one beat at +4
        g_sai = 8'hA1; g_fid = 8'h10; g_bar = 3'd5;
        push_dn(4'h4, 48'h1004, 4'hF, 32'h0);
        push_rsp(1, RV, 32'hCAFEF00D, 1'b1);
        push_up(RV, 64'hCAFEF00D_00000000, 1'b1, 1);
        send(4'h4, 48'h1000, 8'hF0, 64'h0);
        wait_done(100);

        // first beat misses: no second beat, miss one cycle after the ack
        d0 = dn_cnt;
        push_dn(4'h0, 48'h2008, 4'hF, 32'h0);
        push_rsp(1, RM, 0, 1'b1);
        push_up(RM, 0, 1'b0, 0);
        send(4'h0, 48'h2008, 8'hFF, 64'h0);
        wait_done(100);
        chk("miss_beats", 64'(dn_cnt - d0), 1);
        chk("miss_latency", 64'(ack_cyc - dn_cyc), 2);

        // write ack returned for a read is a miss
        push_dn(4'h2, 48'h2100, 4'hF, 32'h0);
        push_rsp(1, WV, 0, 1'b1);
        push_up(RM, 0, 1'b0, 0);
        send(4'h2, 48'h2100, 8'h0F, 64'h0);
        wait_done(100);

        // minimum latency, misaligned address rounds down
        push_dn(4'h1, 48'h3000, 4'hF, 32'hCCCCDDDD);
        push_rsp(1, WV, 0, 1'b1);
        push_up(WV, 0, 1'b1, 1);
        send(4'h1, 48'h3004, 8'h0F, 64'hAAAABBBB_CCCCDDDD);
        wait_done(100);
        chk("min_lat_dn", 64'(dn_cyc - send_cyc), 1);
        chk("min_lat_ack", 64'(ack_cyc - send_cyc), 3);

        // two-beat read, second beat reports a failed sai
        push_dn(4'h6, 48'h40F0, 4'hF, 32'h0);
        push_dn(4'h6, 48'h40F4, 4'hF, 32'h0);
        push_rsp(2, RV, 32'h0000A0A0, 1'b1); push_rsp(1, RV, 32'hB0B0B0B0, 1'b0);
        push_up(RV, 64'hB0B0B0B0_0000A0A0, 1'b0, 1);
        send(4'h6, 48'h40F3, 8'hFF, 64'h0);
        wait_done(100);

        // partial byte enables in both beats
        push_dn(4'h3, 48'h4200, 4'hC, 32'h05060708);
        push_dn(4'h3, 48'h4204, 4'h3, 32'h01020304);
        push_rsp(1, WV, 0, 1'b1); push_rsp(3, WV, 0, 1'b1);
        push_up(WV, 0, 1'b1, 1);
        send(4'h3, 48'h4200, 8'h3C, 64'h01020304_05060708);
        wait_done(100);

        // timeout: miss 16 cycles after ISSUE, later ack ignored
        push_dn(4'h1, 48'h6000, 4'hF, 32'h9ABCDEF0);
        push_rsp(20, WV, 0, 1'b1);
        push_up(WM, 0, 1'b0, 1);
        send(4'h1, 48'h6000, 8'h0F, 64'h12345678_9ABCDEF0);
        wait_done(100);
        chk("tmo_latency", 64'(ack_cyc - dn_cyc), 16);
        a0 = ack_cnt;
        repeat (25) @(posedge clk);
        #1;
        chk("tmo_late_ignored", 64'(ack_cnt - a0), 0);
        chk("tmo_ready", 64'(bus.up_req_ready), 1);

        // illegal opcodes and an all-zero-be write: no downstream traffic
        d0 = dn_cnt;
        push_up(WM, 0, 1'b0, 0);
        send(4'h9, 48'h7000, 8'hFF, 64'h0);
        wait_done(100);
        push_up(RM, 0, 1'b0, 0);
        send(4'h8, 48'h7000, 8'hFF, 64'h0);
        wait_done(100);
        push_up(WV, 0, 1'b1, 1);
        send(4'h1, 48'h7000, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done(100);
        chk("no_dn_traffic", 64'(dn_cnt - d0), 0);

        // reset during WAIT discards the transaction
        d0 = dn_cnt; a0 = ack_cnt;
        push_dn(4'h0, 48'h5000, 4'hF, 32'h0);
        push_rsp(0, 4'b0, 0, 1'b0);
        send(4'h0, 48'h5000, 8'h0F, 64'h0);
        n = 0;
        while (dn_cnt == d0 && n < 10) begin @(negedge clk); #1; n++; end
        chk("rst_dn_seen", 64'(dn_cnt - d0), 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_quiet("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_no_ack", 64'(ack_cnt - a0), 0);
        push_dn(4'h1, 48'h5000, 4'hF, 32'h76543210);
        push_dn(4'h1, 48'h5004, 4'hF, 32'hFEDCBA98);
        push_rsp(1, WV, 0, 1'b1); push_rsp(1, WV, 0, 1'b1);
        push_up(WV, 0, 1'b1, 1);
        send(4'h1, 48'h5000, 8'hFF, 64'hFEDCBA98_76543210);
        wait_done(100);

        chk("sb_dn_empty", 64'(dn_q.size()), 0);
        chk("sb_up_empty", 64'(up_q.size()), 0);
        chk("sb_rsp_empty", 64'(rsp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
